sram_controller: RTL and testbench

- Sequences multi-cycle accesses from the MEM stage to an external 16-bit asynchronous SRAM. Replaces the single-cycle data memory.
- Each 32-bit load/store becomes two halfword SRAM phases: low half first, then high half.
- Drives `ready` low while busy so the pipeline freezes all stage registers until the access completes.

---
 rtl/arm_mem_pkg.sv | 16 +
 rtl/sram_controller.sv | 132 +++++++++++++
 tb/tb_sram_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared memory-side types and constants for the SRAM-backed data memory.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the access FSM encoding, default CPU base address and SRAM data width.
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_t;

    localparam int BASE_ADDR_DEFAULT = 1024;
    localparam int SRAM_DW           = 16;

endpackage

// File: rtl/sram_controller.sv
// Turns each 32-bit MEM-stage load/store into two halfword async-SRAM phases (low, then high).
// Latency: ready low for 2*(WAIT_CYCLES+1)+1 cycles per access, ready high in DONE.
// Backpressure: ready drops combinationally on a request in IDLE and stays low until DONE.
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int WAIT_CYCLES = 5,
    parameter int SRAM_AW     = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic [31:0]          address,
    input  logic [31:0]          write_data,
    output logic [31:0]          read_data,
    output logic                 ready,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [SRAM_DW-1:0]   sram_dq_out,
    output logic                 sram_dq_oe,
    input  logic [SRAM_DW-1:0]   sram_dq_in,
    output logic                 sram_we_n,
    output logic                 sram_oe_n
);

    localparam int          WIDX_W    = SRAM_AW - 1;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

    sram_state_t        state;
    logic [3:0]         counter;
    logic               op_wr;
    logic [WIDX_W-1:0]  widx;
    logic [31:0]        wdata;

    logic               req;
    logic [WIDX_W-1:0]  widx_in;
    logic               phase_end;

    assign req       = rd_en | wr_en;
    assign widx_in   = WIDX_W'((address - 32'(BASE_ADDR)) >> 2);
    assign phase_end = (counter == WAIT_LAST);

    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = ~req;
            LOW:     ready = 1'b0;
            HIGH:    ready = 1'b0;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Strobes are registered one cycle ahead so they line up exactly with each phase;
    // we_n rises on the last cycle of a write phase to give address/data hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= 4'd0;
            op_wr       <= 1'b0;
            widx        <= '0;
            wdata       <= 32'd0;
            read_data   <= 32'd0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr       <= wr_en;
                        widx        <= widx_in;
                        wdata       <= write_data;
                        counter     <= 4'd0;
                        state       <= LOW;
                        sram_addr   <= {widx_in, 1'b0};
                        sram_dq_out <= write_data[15:0];
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                        sram_oe_n   <= wr_en;
                    end
                end
                LOW: begin
                    if (phase_end) begin
                        counter     <= 4'd0;
                        state       <= HIGH;
                        sram_addr   <= {widx, 1'b1};
                        sram_dq_out <= wdata[31:16];
                        sram_dq_oe  <= op_wr;
                        sram_we_n   <= ~op_wr;
                        sram_oe_n   <= op_wr;
                        if (!op_wr) begin
                            read_data[15:0] <= sram_dq_in;
                        end
                    end else begin
                        counter <= counter + 4'd1;
                        if (counter + 4'd1 == WAIT_LAST) begin
                            sram_we_n <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        counter    <= 4'd0;
                        state      <= DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        if (!op_wr) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                    end else begin
                        counter <= counter + 4'd1;
                        if (counter + 4'd1 == WAIT_LAST) begin
                            sram_we_n <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: directed table, reset/idle corner cases, randomized
// accesses against a word-level reference model, with a behavioural 16-bit async SRAM attached.
module tb_sram_controller;

    localparam int AW   = 18;
    localparam int W    = 5;
    localparam int BASE = 1024;
    localparam int LAT  = 2 * (W + 1) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en, rd_en;
    logic [31:0]     address, write_data;
    logic [31:0]     read_data;
    logic            ready;
    logic [AW-1:0]   sram_addr;
    logic [15:0]     sram_dq_out;
    logic            sram_dq_oe;
    logic [15:0]     sram_dq_in;
    logic            sram_we_n, sram_oe_n;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // sram_model: 16-bit x 2^AW array, written while we_n is low, driven only when oe_n is low.
    logic [15:0] sram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1)
            sram_mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = (sram_oe_n == 1'b0 && sram_dq_oe == 1'b0) ? sram_mem[sram_addr] : 16'hDEAD;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Per-cycle SRAM pin trace of the current access (cycles with ready=0).
    logic [AW-1:0] tr_addr[$];
    logic [15:0]   tr_dqo[$];
    logic          tr_we[$], tr_oe[$], tr_dqoe[$];

    task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] data,
                             output int nlow, output int start_c, output int done_c, output bit first_low);
        tr_addr.delete(); tr_dqo.delete(); tr_we.delete(); tr_oe.delete(); tr_dqoe.delete();
        @(negedge clk);
        wr_en = wr; rd_en = rd; address = addr; write_data = data;
        start_c = cyc;
        done_c = -1;
        nlow = 0;
        #1;
        first_low = (ready == 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (ready == 1'b0) begin
                nlow++;
                tr_addr.push_back(sram_addr); tr_dqo.push_back(sram_dq_out);
                tr_we.push_back(sram_we_n); tr_oe.push_back(sram_oe_n); tr_dqoe.push_back(sram_dq_oe);
            end else if (nlow > 0) begin
                done_c = cyc;
                return;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    // Expected pin behaviour derived from the phase rules: one IDLE cycle, then W+1 cycles
    // per halfword phase; writes pulse we_n low on all but the last cycle of each phase.
    function automatic bit trace_ok(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        logic [AW-2:0] widx;
        widx = (AW-1)'((addr - BASE) >> 2);
        if (tr_addr.size() != LAT) return 1'b0;
        if (tr_we[0] !== 1'b1 || tr_oe[0] !== 1'b1 || tr_dqoe[0] !== 1'b0) return 1'b0;
        for (int k = 1; k < LAT; k++) begin
            int ph, j;
            ph = (k - 1) / (W + 1);
            j  = (k - 1) % (W + 1);
            if (tr_addr[k] !== {widx, ph[0]}) return 1'b0;
            if (wr) begin
                if (tr_dqoe[k] !== 1'b1 || tr_oe[k] !== 1'b1) return 1'b0;
                if (tr_we[k] !== (j == W)) return 1'b0;
                if (tr_dqo[k] !== (ph == 0 ? data[15:0] : data[31:16])) return 1'b0;
            end else begin
                if (tr_dqoe[k] !== 1'b0 || tr_oe[k] !== 1'b0 || tr_we[k] !== 1'b1) return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[6];
    logic [31:0] model_mem [int];

    initial begin
        int nlow, sc, dc, sc_pair;
        bit fl, b2b_ok;
        logic [31:0] exp_rd;
        logic [AW-2:0] widx;

        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
        wr_en = 0; rd_en = 0; address = 0; write_data = 0;
        rst = 1'b1;
        #1;
        check(read_data == 32'd0 && sram_we_n && sram_oe_n && !sram_dq_oe && sram_addr == '0
              && sram_dq_out == 16'd0, "reset_outputs", read_data, 32'd0);
        check(ready == 1'b1, "reset_ready", {31'd0, ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle: no request keeps ready high and the SRAM bus quiet.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            check(ready && sram_we_n && sram_oe_n && !sram_dq_oe, "idle",
                  {28'd0, ready, sram_we_n, sram_oe_n, sram_dq_oe}, 32'hE);
        end

        vecs[0] = '{wr: 1, rd: 0, addr: 32'd1032, data: 32'h1234ABCD, exp_rd: 32'h00000000};
        vecs[1] = '{wr: 0, rd: 1, addr: 32'd1032, data: 32'h0,        exp_rd: 32'h1234ABCD};
        vecs[2] = '{wr: 1, rd: 0, addr: 32'd1024, data: 32'hCAFEF00D, exp_rd: 32'h1234ABCD};
        vecs[3] = '{wr: 0, rd: 1, addr: 32'd1024, data: 32'h0,        exp_rd: 32'hCAFEF00D};
        vecs[4] = '{wr: 1, rd: 1, addr: 32'd1028, data: 32'h00000055, exp_rd: 32'hCAFEF00D};
        vecs[5] = '{wr: 0, rd: 1, addr: 32'd1030, data: 32'h0,        exp_rd: 32'h00000055};

        sc_pair = 0;
        for (int v = 0; v < 6; v++) begin
            do_access(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].data, nlow, sc, dc, fl);
            check(fl && nlow == LAT, $sformatf("vec%0d_latency", v), nlow, LAT);
            check(dc - sc + 1 == LAT + 1, $sformatf("vec%0d_total", v), dc - sc + 1, LAT + 1);
            check(read_data === vecs[v].exp_rd, $sformatf("vec%0d_read_data", v), read_data, vecs[v].exp_rd);
            check(trace_ok(vecs[v].wr, vecs[v].addr, vecs[v].data), $sformatf("vec%0d_pins", v), 0, 1);
            if (vecs[v].wr) begin
                widx = (AW-1)'((vecs[v].addr - BASE) >> 2);
                check({sram_mem[{widx, 1'b1}], sram_mem[{widx, 1'b0}]} === vecs[v].data,
                      $sformatf("vec%0d_sram", v), {sram_mem[{widx, 1'b1}], sram_mem[{widx, 1'b0}]}, vecs[v].data);
            end
            if (v == 2) sc_pair = sc;
            if (v == 3) begin
                b2b_ok = (dc - sc_pair + 1 == 2 * (LAT + 1));
                check(b2b_ok, "back_to_back_total", dc - sc_pair + 1, 2 * (LAT + 1));
            end
        end
        check(sram_mem[4] === 16'hABCD && sram_mem[5] === 16'h1234, "hw45",
              {sram_mem[5], sram_mem[4]}, 32'h1234ABCD);
        check(sram_mem[2] === 16'h0055 && sram_mem[3] === 16'h0000, "hw23",
              {sram_mem[3], sram_mem[2]}, 32'h00000055);
        idle_cycles(2);

        // Reset during the third cycle of HIGH of a load.
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b0; address = 32'd1032;
        repeat (9) @(negedge clk);
        #1;
        check(sram_oe_n == 1'b0 && read_data[15:0] == 16'hABCD, "pre_reset_high",
              {15'd0, sram_oe_n, read_data[15:0]}, 32'h0000ABCD);
        rst = 1'b1;
        #1;
        check(sram_we_n && sram_oe_n && !sram_dq_oe && read_data == 32'd0, "midop_reset",
              read_data, 32'd0);
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check(ready == 1'b1, "post_reset_ready", {31'd0, ready}, 32'd1);
        do_access(1'b0, 1'b1, 32'd1032, 32'd0, nlow, sc, dc, fl);
        check(fl && nlow == LAT, "post_reset_latency", nlow, LAT);
        check(read_data === 32'h1234ABCD, "post_reset_load", read_data, 32'h1234ABCD);
        idle_cycles(1);

        // Randomized accesses against a word-level model.
        model_mem[0] = 32'hCAFEF00D;
        model_mem[1] = 32'h00000055;
        model_mem[2] = 32'h1234ABCD;
        exp_rd = 32'h1234ABCD;
        for (int it = 0; it < 40; it++) begin
            int op, w, gap;
            bit wr, rd;
            logic [31:0] data;
            op   = $urandom_range(0, 2);
            w    = $urandom_range(0, 15);
            gap  = $urandom_range(0, 2);
            data = $urandom;
            wr   = (op != 0);
            rd   = (op != 1);
            if (gap > 0) idle_cycles(gap);
            do_access(wr, rd, BASE + 4 * w, data, nlow, sc, dc, fl);
            if (wr) model_mem[w] = data;
            else exp_rd = model_mem.exists(w) ? model_mem[w] : 32'd0;
            check(fl && nlow == LAT, $sformatf("rnd%0d_latency", it), nlow, LAT);
            check(read_data === exp_rd, $sformatf("rnd%0d_read_data", it), read_data, exp_rd);
            check(trace_ok(wr, BASE + 4 * w, data), $sformatf("rnd%0d_pins", it), 0, 1);
        end
        idle_cycles(2);
        for (int w = 0; w < 16; w++) begin
            logic [31:0] m;
            m = model_mem.exists(w) ? model_mem[w] : 32'd0;
            check({sram_mem[2*w+1], sram_mem[2*w]} === m, $sformatf("final_word%0d", w),
                  {sram_mem[2*w+1], sram_mem[2*w]}, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
